// File: rtl/enc_4_a_2_sync_pkg.sv
// Shared DPWM phase-select definitions: active-low phase codes, readback FSM
// encoding and the code-to-index decoders used by enc_4_a_2_sync.
package enc_4_a_2_sync_pkg;

  localparam logic [3:0] PH0_N     = 4'b1110;
  localparam logic [3:0] PH1_N     = 4'b1101;
  localparam logic [3:0] PH2_N     = 4'b1011;
  localparam logic [3:0] PH3_N     = 4'b0111;
  localparam logic [3:0] PH_IDLE_N = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    PEND  = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } dec_t;

  function automatic dec_t decode_strict(input logic [3:0] c);
    dec_t d;
    d = '{legal: 1'b0, idx: 2'd0};
    case (c)
      PH0_N:   d = '{legal: 1'b1, idx: 2'd0};
      PH1_N:   d = '{legal: 1'b1, idx: 2'd1};
      PH2_N:   d = '{legal: 1'b1, idx: 2'd2};
      PH3_N:   d = '{legal: 1'b1, idx: 2'd3};
      default: d = '{legal: 1'b0, idx: 2'd0};
    endcase
    return d;
  endfunction

  // Lowest-index low bit wins; only the all-high idle code is not legal.
  function automatic dec_t decode_priority(input logic [3:0] c);
    dec_t d;
    d = '{legal: 1'b0, idx: 2'd0};
    if (!c[0])      d = '{legal: 1'b1, idx: 2'd0};
    else if (!c[1]) d = '{legal: 1'b1, idx: 2'd1};
    else if (!c[2]) d = '{legal: 1'b1, idx: 2'd2};
    else if (!c[3]) d = '{legal: 1'b1, idx: 2'd3};
    return d;
  endfunction

endpackage

// File: rtl/enc_4_a_2_sync_sync_filt_4.sv
// Synchronizer chain plus stability filter for the four phase readback lines.
// Emits the filtered code and a one-cycle commit strobe per new stable code.
module sync_filt_4 #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  localparam int FILT_W = $clog2(FILT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic [3:0] in_n_i,
  output logic [3:0] code_o,
  output logic       commit_o
);

  logic [3:0]        sync_q [SYNC_STAGES];
  logic [3:0]        last_q, last_d;
  logic [3:0]        committed_q, committed_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic [3:0]        s;

  assign s = sync_q[SYNC_STAGES-1];

  // Commit is judged on the values taken at this edge, so a clean change
  // commits SYNC_STAGES + FILT_CYCLES edges after it is applied.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (s != last_q) begin
      last_d = s;
      cnt_d  = FILT_W'(1);
    end else if (cnt_q != FILT_W'(FILT_CYCLES)) begin
      cnt_d = cnt_q + FILT_W'(1);
    end
    if (clr_i) cnt_d = '0;
    commit_o    = !clr_i && (cnt_d == FILT_W'(FILT_CYCLES)) && (last_d != committed_q);
    committed_d = clr_i ? 4'hF : (commit_o ? last_d : committed_q);
    code_o      = last_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
      last_q      <= 4'hF;
      committed_q <= 4'hF;
      cnt_q       <= '0;
    end else begin
      sync_q[0] <= in_n_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      last_q      <= last_d;
      committed_q <= committed_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/enc_4_a_2_sync.sv
// DPWM phase-select readback: filters IN_N, encodes to a 2-bit index and hands
// it off over valid/ready. Optional macro ENC_PRIORITY_EN: priority-encode multi-low codes.
module enc_4_a_2_sync
  import enc_4_a_2_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EN,
  input  logic [3:0] IN_N,
  output logic [1:0] OUT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       ACTIVE,
  output logic       ERR,
  output logic       OVR
);

  logic [3:0] code;
  logic       commit, legal_commit;
  dec_t       dec;
  state_t     state_q, state_d;
  logic [1:0] out_q, out_d;
  logic       active_q, active_d, err_q, err_d, ovr_q, ovr_d;

  sync_filt_4 #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (~EN),
    .in_n_i  (IN_N),
    .code_o  (code),
    .commit_o(commit)
  );

`ifdef ENC_PRIORITY_EN
  localparam bit ERR_EN = 1'b0;
  assign dec = decode_priority(code);
`else
  localparam bit ERR_EN = 1'b1;
  assign dec = decode_strict(code);
`endif

  assign legal_commit = commit && dec.legal;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    active_d = active_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    if (!EN) begin
      state_d  = IDLE;
      active_d = 1'b0;
      err_d    = 1'b0;
      ovr_d    = 1'b0;
    end else begin
      if (commit) begin
        if (dec.legal) begin
          out_d    = dec.idx;
          active_d = 1'b1;
        end else begin
          active_d = 1'b0;
          if (ERR_EN && (code != PH_IDLE_N)) err_d = 1'b1;
        end
      end
      case (state_q)
        IDLE:  state_d = TRACK;
        TRACK: if (legal_commit) state_d = PEND;
        PEND: begin
          if (legal_commit) begin
            if (!OUT_READY) ovr_d = 1'b1;
          end else if (OUT_READY) begin
            state_d = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= 2'b00;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      active_q <= active_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = (state_q == PEND);
  assign ACTIVE    = active_q;
  assign ERR       = err_q;
  assign OVR       = ovr_q;

endmodule

// File: tb/tb_enc_4_a_2_sync.sv
// Directed bench for enc_4_a_2_sync: a table of timed steps checked as
// {OUT, OUT_VALID, ACTIVE, ERR, OVR}, plus an asynchronous reset sequence.
module tb_enc_4_a_2_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       EN;
  logic [3:0] IN_N;
  logic [1:0] OUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       ACTIVE;
  logic       ERR;
  logic       OVR;

  int pass_cnt = 0;
  int total_cnt = 0;

  enc_4_a_2_sync #(
    .SYNC_STAGES(2),
    .FILT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .EN       (EN),
    .IN_N     (IN_N),
    .OUT      (OUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .ACTIVE   (ACTIVE),
    .ERR      (ERR),
    .OVR      (OVR)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       en;
    logic [3:0] in_n;
    logic       rdy;
    int         n;
    logic [5:0] exp;   // {OUT[1:0], OUT_VALID, ACTIVE, ERR, OVR}
  } step_t;

  step_t steps[$];

  function automatic step_t mk(input string nm, input logic en, input logic [3:0] in_n,
                               input logic rdy, input int n, input logic [1:0] o,
                               input logic v, input logic a, input logic e, input logic ov);
    step_t s;
    s.nm   = nm;
    s.en   = en;
    s.in_n = in_n;
    s.rdy  = rdy;
    s.n    = n;
    s.exp  = {o, v, a, e, ov};
    return s;
  endfunction

  function automatic logic [5:0] outs();
    return {OUT, OUT_VALID, ACTIVE, ERR, OVR};
  endfunction

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {out,vld,act,err,ovr}=%b expected %b", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    steps.push_back(mk("lat_before",   1, 4'b1110, 1, 5, 2'b00, 0, 0, 0, 0));
    steps.push_back(mk("lat_edge6",    1, 4'b1110, 1, 1, 2'b00, 1, 1, 0, 0));
    steps.push_back(mk("handshake",    1, 4'b1110, 1, 1, 2'b00, 0, 1, 0, 0));
    steps.push_back(mk("ph3_before",   1, 4'b0111, 0, 5, 2'b00, 0, 1, 0, 0));
    steps.push_back(mk("ph3_commit",   1, 4'b0111, 0, 1, 2'b11, 1, 1, 0, 0));
    steps.push_back(mk("ph2_pending",  1, 4'b1011, 0, 5, 2'b11, 1, 1, 0, 0));
    steps.push_back(mk("ph2_overrun",  1, 4'b1011, 0, 1, 2'b10, 1, 1, 0, 1));
    steps.push_back(mk("ovr_ack",      1, 4'b1011, 1, 1, 2'b10, 0, 1, 0, 1));
    steps.push_back(mk("ph0_again",    1, 4'b1110, 1, 7, 2'b00, 0, 1, 0, 1));
    steps.push_back(mk("glitch_in",    1, 4'b1101, 1, 2, 2'b00, 0, 1, 0, 1));
    steps.push_back(mk("glitch_after", 1, 4'b1110, 1, 10, 2'b00, 0, 1, 0, 1));
`ifdef ENC_PRIORITY_EN
    steps.push_back(mk("multi_low",    1, 4'b1100, 1, 6, 2'b00, 1, 1, 0, 1));
    steps.push_back(mk("pend_ph3",     1, 4'b0111, 0, 6, 2'b11, 1, 1, 0, 1));
`else
    steps.push_back(mk("multi_low",    1, 4'b1100, 1, 6, 2'b00, 0, 0, 1, 1));
    steps.push_back(mk("pend_ph3",     1, 4'b0111, 0, 6, 2'b11, 1, 1, 1, 1));
`endif
    steps.push_back(mk("en_drop",      0, 4'b0111, 0, 1, 2'b11, 0, 0, 0, 0));
    steps.push_back(mk("idle_hold",    0, 4'b0111, 0, 3, 2'b11, 0, 0, 0, 0));
    steps.push_back(mk("reen_before",  1, 4'b0111, 0, 3, 2'b11, 0, 0, 0, 0));
    steps.push_back(mk("reen_commit",  1, 4'b0111, 0, 1, 2'b11, 1, 1, 0, 0));
    steps.push_back(mk("ph1_pending",  1, 4'b1101, 0, 5, 2'b11, 1, 1, 0, 0));
    steps.push_back(mk("hs_and_commit",1, 4'b1101, 1, 1, 2'b01, 1, 1, 0, 0));
    steps.push_back(mk("hs_after",     1, 4'b1101, 1, 1, 2'b01, 0, 1, 0, 0));
    steps.push_back(mk("idle_code",    1, 4'b1111, 1, 6, 2'b01, 0, 0, 0, 0));

    reset     = 1'b1;
    EN        = 1'b1;
    IN_N      = 4'b1110;
    OUT_READY = 1'b1;
    #2;
    check("reset_state", outs(), 6'b000000);
    #1;
    reset = 1'b0;

    for (int i = 0; i < steps.size(); i++) begin
      EN        = steps[i].en;
      IN_N      = steps[i].in_n;
      OUT_READY = steps[i].rdy;
      tick(steps[i].n);
      check(steps[i].nm, outs(), steps[i].exp);
    end

    // Asynchronous reset from a pending state, landing mid-filter.
    IN_N      = 4'b0111;
    OUT_READY = 1'b0;
    tick(6);
    check("pre_reset_pend", outs(), {2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
    IN_N = 4'b1110;
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), 6'b000000);
    @(posedge clk);
    #1;
    check("reset_held", outs(), 6'b000000);
    reset     = 1'b0;
    OUT_READY = 1'b1;
    tick(5);
    check("post_reset_before", outs(), 6'b000000);
    tick(1);
    check("post_reset_commit", outs(), {2'b00, 1'b1, 1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
